// File: rtl/sound_gen_pkg.sv
// Shared types and default tone periods for the multi-event sound generator.
package sound_gen_pkg;

   typedef enum logic [1:0] {
      SG_IDLE,
      SG_PLAY,
      SG_GAP
   } sg_state_t;

   typedef enum logic {
      WAVE_SQUARE,
      WAVE_SAW
   } wave_mode_t;

   localparam int unsigned SG_DEF_DIV_W = 16;

   localparam logic [15:0] SG_PER_GOOD_COLL = 16'd28409;
   localparam logic [15:0] SG_PER_BAD_COLL  = 16'd56818;
   localparam logic [15:0] SG_PER_BUTTON    = 16'd37936;

   localparam logic [3:0][15:0] SG_PER_DIR = {
      16'd47801,
      16'd42589,
      16'd37936,
      16'd31888
   };

endpackage

// File: rtl/sg_tone_osc.sv
// Phase counter with square/saw generation; outputs are the values
// the oscillator will hold after the coming clock edge.
module sg_tone_osc #(
   parameter int N     = 8,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [DIV_W-1:0] i_period,
   output logic             o_sq,
   output logic [N-1:0]     o_saw
);

   logic [DIV_W-1:0] r_phase;
   logic             r_sq;
   logic [N-1:0]     r_saw;

   logic [DIV_W-1:0] w_last;
   logic [DIV_W-1:0] w_phase_nxt;
   logic             w_sq_nxt;
   logic [N-1:0]     w_saw_nxt;

   // A zero period behaves like a period of one.
   assign w_last = (i_period == '0) ? '0 : i_period - DIV_W'(1);

   always_comb begin
      w_phase_nxt = r_phase;
      w_sq_nxt    = r_sq;
      w_saw_nxt   = r_saw;
      if (i_load) begin
         w_phase_nxt = '0;
         w_sq_nxt    = 1'b1;
         w_saw_nxt   = '0;
      end else if (i_en) begin
         if (r_phase == w_last) begin
            w_phase_nxt = '0;
            w_sq_nxt    = ~r_sq;
            w_saw_nxt   = r_saw + N'(1);
         end else begin
            w_phase_nxt = r_phase + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= '0;
         r_sq    <= 1'b0;
         r_saw   <= '0;
      end else begin
         r_phase <= w_phase_nxt;
         r_sq    <= w_sq_nxt;
         r_saw   <= w_saw_nxt;
      end
   end

   assign o_sq  = w_sq_nxt;
   assign o_saw = w_saw_nxt;

endmodule

// File: rtl/multi_event_sound_gen.sv
// Multi-event tone generator: edge detect, fixed-priority arbitration,
// play/gap sequencing and attenuated square/saw DAC output.
module multi_event_sound_gen
   import sound_gen_pkg::*;
#(
   parameter int N         = 8,
   parameter int NUM_EVT   = 7,
   parameter int DIV_W     = 16,
   parameter int DUR_TICKS = 1200000,
   parameter int GAP_TICKS = 120000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_EVT-1:0]         evt_i,
   input  logic [NUM_EVT*DIV_W-1:0]   evt_period_i,
   input  logic                       wave_mode_i,
   input  logic [1:0]                 vol_i,
   output logic [N-1:0]               dacCount,
   output logic                       busy_o,
   output logic [((NUM_EVT > 1) ? $clog2(NUM_EVT) : 1)-1:0] active_evt_o
);

   localparam int AW  = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
   localparam int DCW = (DUR_TICKS > 1) ? $clog2(DUR_TICKS) : 1;
   localparam int GCW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

   sg_state_t r_state;
   sg_state_t w_state_nxt;

   logic [NUM_EVT-1:0] r_evt_q;
   logic [NUM_EVT-1:0] r_evt_prev;
   logic [AW-1:0]      r_active;
   logic [DIV_W-1:0]   r_period;
   logic [DCW-1:0]     r_dur;
   logic [GCW-1:0]     r_gap;
   logic [N-1:0]       r_dac;
   logic               r_busy;

   logic [NUM_EVT-1:0] w_edge;
   logic               w_any;
   logic [AW-1:0]      w_win;
   logic [DIV_W-1:0]   w_win_per;
   logic               w_retrig;
   logic               w_dur_end;
   logic               w_gap_end;
   logic               w_load;
   logic               w_en;
   logic               w_osc_sq;
   logic [N-1:0]       w_osc_saw;
   logic [N-1:0]       w_full;
   logic [N-1:0]       w_dac_nxt;

   assign w_edge    = r_evt_q & ~r_evt_prev;
   assign w_any     = |w_edge;
   assign w_full    = '1;
   assign w_dur_end = (r_dur == DCW'(DUR_TICKS - 1));
   assign w_gap_end = (r_gap == GCW'(GAP_TICKS - 1));
   assign w_retrig  = w_any && (w_win <= r_active);

   always_comb begin
      w_win     = '0;
      w_win_per = '0;
      for (int i = NUM_EVT - 1; i >= 0; i--) begin
         if (w_edge[i]) begin
            w_win     = AW'(i);
            w_win_per = evt_period_i[i*DIV_W +: DIV_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_evt_q    <= '0;
         r_evt_prev <= '0;
      end else begin
         r_evt_q    <= evt_i;
         r_evt_prev <= r_evt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SG_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A qualifying retrigger beats tone expiry.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         SG_IDLE: if (w_any) w_state_nxt = SG_PLAY;
         SG_PLAY: if (!w_retrig && w_dur_end) w_state_nxt = SG_GAP;
         SG_GAP:  if (w_gap_end) w_state_nxt = SG_IDLE;
         default: w_state_nxt = SG_IDLE;
      endcase
   end

   always_comb begin
      w_load    = ((r_state == SG_IDLE) && w_any) ||
                  ((r_state == SG_PLAY) && w_retrig);
      w_en      = (r_state == SG_PLAY);
      w_dac_nxt = '0;
      if (w_state_nxt == SG_PLAY) begin
         if (wave_mode_t'(wave_mode_i) == WAVE_SAW) begin
            w_dac_nxt = w_osc_saw >> vol_i;
         end else if (w_osc_sq) begin
            w_dac_nxt = w_full >> vol_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_active <= '0;
         r_period <= '0;
         r_dur    <= '0;
         r_gap    <= '0;
      end else begin
         if (w_load) begin
            r_active <= w_win;
            r_period <= w_win_per;
            r_dur    <= '0;
         end else if ((r_state == SG_PLAY) && !w_dur_end) begin
            r_dur <= r_dur + DCW'(1);
         end
         if ((r_state == SG_PLAY) && (w_state_nxt == SG_GAP)) begin
            r_gap <= '0;
         end else if ((r_state == SG_GAP) && !w_gap_end) begin
            r_gap <= r_gap + GCW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dac  <= '0;
         r_busy <= 1'b0;
      end else begin
         r_dac  <= w_dac_nxt;
         r_busy <= (w_state_nxt != SG_IDLE);
      end
   end

   sg_tone_osc #(
      .N     (N),
      .DIV_W (DIV_W)
   ) u_osc (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_en     (w_en),
      .i_period (r_period),
      .o_sq     (w_osc_sq),
      .o_saw    (w_osc_saw)
   );

   assign dacCount     = r_dac;
   assign busy_o       = r_busy;
   assign active_evt_o = r_active;

endmodule

// File: tb/tb_multi_event_sound_gen.sv
// Bench for multi_event_sound_gen: vector table, directed corner cases,
// and randomized traffic against a closed-form reference model.
module tb_multi_event_sound_gen;

   localparam int DUR = 20;
   localparam int GAP = 4;

   typedef struct {
      logic [3:0] evt;
      int         dac;
      int         busy;
      int         act;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  evt = '0;
   logic [31:0] per = '0;
   logic        wave = 1'b0;
   logic [1:0]  vol = '0;

   logic [7:0]  dac_a, dac_b;
   logic        busy_a, busy_b;
   logic [1:0]  act_a, act_b;

   int n_pass  = 0;
   int n_total = 0;

   int         m_st, m_act, m_per, m_t, m_g;
   logic [3:0] m_q, m_prev;
   int         e_dac, e_busy;

   always #5 clk = ~clk;

   multi_event_sound_gen #(
      .N(8), .NUM_EVT(4), .DIV_W(8),
      .DUR_TICKS(DUR), .GAP_TICKS(GAP)
   ) dut_a (
      .clk(clk), .rst(rst), .evt_i(evt),
      .evt_period_i(per), .wave_mode_i(wave), .vol_i(vol),
      .dacCount(dac_a), .busy_o(busy_a), .active_evt_o(act_a)
   );

   multi_event_sound_gen #(
      .N(8), .NUM_EVT(4), .DIV_W(8),
      .DUR_TICKS(300), .GAP_TICKS(GAP)
   ) dut_b (
      .clk(clk), .rst(rst), .evt_i(evt),
      .evt_period_i(per), .wave_mode_i(wave), .vol_i(vol),
      .dacCount(dac_b), .busy_o(busy_b), .active_evt_o(act_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
   endtask

   task automatic set_per(input int e, input int v);
      per[e*8 +: 8] = 8'(v);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      evt = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Reference: state plus time since load; waveform from closed form.
   task automatic model_step();
      logic [3:0] edg;
      int win, p, k;
      if (rst) begin
         m_st = 0; m_act = 0; m_per = 0; m_t = 0; m_g = 0;
         m_q = '0; m_prev = '0;
      end else begin
         edg = m_q & ~m_prev;
         win = -1;
         for (int i = 0; i < 4; i++)
            if (edg[i] && win < 0) win = i;
         case (m_st)
            0: if (win >= 0) begin
                  m_st = 1; m_act = win;
                  m_per = int'(per[win*8 +: 8]); m_t = 0;
               end
            1: if (win >= 0 && win <= m_act) begin
                  m_act = win; m_per = int'(per[win*8 +: 8]); m_t = 0;
               end else if (m_t == DUR - 1) begin
                  m_st = 2; m_g = 0;
               end else m_t++;
            default: if (m_g == GAP - 1) m_st = 0; else m_g++;
         endcase
         m_prev = m_q;
         m_q = evt;
      end
      e_busy = (m_st != 0) ? 1 : 0;
      e_dac = 0;
      if (m_st == 1) begin
         p = (m_per == 0) ? 1 : m_per;
         k = m_t / p;
         if (wave) e_dac = (k % 256) >> vol;
         else e_dac = (k % 2 == 0) ? (255 >> vol) : 0;
      end
   endtask

   initial begin
      vec_t tbl [26];
      int cnt, seen3, extra;

      rst = 1'b1;
      step();
      step();
      chk("reset dac", int'(dac_a), 0);
      chk("reset busy", int'(busy_a), 0);
      chk("reset act", int'(act_a), 0);
      rst = 1'b0;

      tbl[0] = '{evt: 4'b0100, dac: 0, busy: 0, act: 0};
      for (int c = 0; c < DUR; c++)
         tbl[1+c] = '{evt: 4'b0000, dac: ((c / 3) % 2 == 0) ? 255 : 0,
                      busy: 1, act: 2};
      for (int g = 0; g < GAP; g++)
         tbl[1+DUR+g] = '{evt: 4'b0000, dac: 0, busy: 1, act: 2};
      tbl[25] = '{evt: 4'b0000, dac: 0, busy: 0, act: 2};

      set_per(2, 3);
      for (int i = 0; i < 26; i++) begin
         evt = tbl[i].evt;
         step();
         chk($sformatf("sq[%0d] dac", i), int'(dac_a), tbl[i].dac);
         chk($sformatf("sq[%0d] busy", i), int'(busy_a), tbl[i].busy);
         chk($sformatf("sq[%0d] act", i), int'(act_a), tbl[i].act);
      end

      for (int e = 0; e < 4; e++) set_per(e, 2);
      evt = 4'b1010; step();
      evt = 4'b0000; step();
      chk("prio act", int'(act_a), 1);
      chk("prio busy", int'(busy_a), 1);
      repeat (4) step();
      evt = 4'b1000; step();
      evt = 4'b0000; step();
      chk("low prio ignored", int'(act_a), 1);
      evt = 4'b0001; step();
      evt = 4'b0000; step();
      chk("retrig act", int'(act_a), 0);
      chk("retrig dac", int'(dac_a), 255);
      cnt = 1;
      seen3 = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (act_a == 2'd3) seen3 = 1;
         if (!busy_a) break;
         cnt++;
      end
      chk("retrig busy len", cnt, DUR + GAP);
      chk("evt3 never played", seen3, 0);

      evt = 4'b0010; step();
      evt = 4'b0000; step();
      repeat (DUR - 1) step();
      step();
      chk("gap dac", int'(dac_a), 0);
      chk("gap busy", int'(busy_a), 1);
      evt = 4'b0001; step();
      evt = 4'b0000; step();
      step();
      chk("gap last busy", int'(busy_a), 1);
      step();
      chk("gap end schedule", int'(busy_a), 0);
      step();
      step();
      chk("gap edge dropped", int'(busy_a), 0);
      evt = 4'b0001; step();
      evt = 4'b0000; step();
      chk("idle replay busy", int'(busy_a), 1);
      chk("idle replay act", int'(act_a), 0);

      repeat (4) step();
      chk("pre-reset dac", int'(dac_a), 255);
      rst = 1'b1; step();
      chk("mid rst dac", int'(dac_a), 0);
      chk("mid rst busy", int'(busy_a), 0);
      chk("mid rst act", int'(act_a), 0);

      evt = 4'b0100; step();
      rst = 1'b0; step();
      chk("held edge k busy", int'(busy_a), 0);
      step();
      chk("held busy", int'(busy_a), 1);
      chk("held act", int'(act_a), 2);
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (!busy_a) break;
         cnt++;
      end
      chk("held tone len", cnt, DUR + GAP);
      extra = 0;
      repeat (10) begin
         step();
         if (busy_a) extra++;
      end
      chk("held no retrig", extra, 0);
      evt = 4'b0000;

      set_per(1, 0);
      vol = 2'd1;
      evt = 4'b0010; step();
      evt = 4'b0000; step();
      chk("per0 c0", int'(dac_a), 127);
      step();
      chk("per0 c1", int'(dac_a), 0);
      step();
      chk("per0 c2", int'(dac_a), 127);
      step();
      chk("per0 c3", int'(dac_a), 0);
      vol = 2'd0;
      repeat (30) step();

      do_reset();
      wave = 1'b1;
      vol = 2'd2;
      set_per(3, 1);
      evt = 4'b1000; step();
      evt = 4'b0000; step();
      for (int t = 0; t < 300; t++) begin
         if (t > 0) step();
         chk($sformatf("saw t%0d", t), int'(dac_b), (t % 256) >> 2);
      end
      step();
      chk("saw gap dac", int'(dac_b), 0);
      chk("saw gap busy", int'(busy_b), 1);

      for (int i = 0; i < 3000; i++) begin
         rst = (i == 0) || ($urandom_range(0, 299) == 0);
         for (int e = 0; e < 4; e++)
            if ($urandom_range(0, 15) == 0) evt[e] = ~evt[e];
         if ($urandom_range(0, 19) == 0) vol = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) wave = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0)
            set_per(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
         model_step();
         step();
         chk($sformatf("rnd%0d dac", i), int'(dac_a), e_dac);
         chk($sformatf("rnd%0d busy", i), int'(busy_a), e_busy);
         chk($sformatf("rnd%0d act", i), int'(act_a), m_act);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multi_event_sound_gen.md
# multi_event_sound_gen

Parametrised successor to the single-voice game sound generator. Takes NUM_EVT game-event inputs, detects rising edges, and arbitrates them by fixed priority. Plays the winning event's tone for a bounded duration, followed by a mandatory silence gap. Output is an N-bit DAC code, with selectable square or sawtooth waveform and 2-bit volume attenuation. Sits between the game-logic collision/input signals and the DAC pins.

## Interface
Parameters:
- N, 8, DAC code width
- NUM_EVT, 7, number of event inputs (index 0 = highest priority)
- DIV_W, 16, per-event tone period width
- DUR_TICKS, 1200000, tone length in clk cycles (≥1)
- GAP_TICKS, 120000, silence after each tone in clk cycles (≥1)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- evt_i  in  NUM_EVT  event levels, synchronous to clk
- evt_period_i  in  NUM_EVT*DIV_W  flattened per-event period; event e at bits [e*DIV_W +: DIV_W]
- wave_mode_i  in  1  0 = square, 1 = sawtooth
- vol_i  in  2  attenuation, right shift 0–3
- dacCount  out  N  DAC code
- busy_o  out  1  high in PLAY or GAP
- active_evt_o  out  max(1,$clog2(NUM_EVT))  index of event currently playing

## Operation
- Edge detection:
  - evt_i is registered into evt_q; evt_prev is evt_q delayed one cycle.
  - edge = evt_q & ~evt_prev.
  - evt_q and evt_prev reset to 0, so an input already high at reset release produces one edge.
- Arbitration: lowest set index of edge wins. Other simultaneous edges are dropped, not queued.
- FSM states: SG_IDLE, SG_PLAY, SG_GAP.
  - IDLE with any edge → PLAY. Load active index, period, phase=0, dur=0, saw=0, sq=1.
  - PLAY with winning edge of index ≤ active index → retrigger: same load as entry; busy_o stays high.
  - PLAY with edge of index > active index → ignored.
  - PLAY with dur == DUR_TICKS-1 and no retrigger → GAP, gap=0. A qualifying retrigger takes precedence over expiry.
  - GAP: all edges ignored. When gap == GAP_TICKS-1 → IDLE.
- Oscillator (PLAY only):
  - Effective period P = evt_period (0 treated as 1).
  - phase counts 0..P-1. When phase == P-1, it wraps to 0; sq toggles and saw increments mod 2^N.
- Output:
  - In PLAY: square = sq ? (2^N-1)>>vol_i : 0; sawtooth = saw>>vol_i.
  - In IDLE and GAP: dacCount = 0.
  - vol_i and wave_mode_i are sampled every cycle and are not latched.
- active_evt_o holds its last value in GAP/IDLE.
- Reset mid-tone: next edge goes to IDLE. All counters are 0; dacCount=0, busy_o=0, active_evt_o=0.

## Timing
- All outputs are registered. Reset values: dacCount=0, busy_o=0, active_evt_o=0.
- Latency:
  - evt_i rises before edge k; evt_q=1 at k.
  - State=PLAY at edge k+1. From then: busy_o=1, active_evt_o valid, dacCount = (2^N-1)>>vol (square) or 0 (saw).
- Square period is 2·P cycles. Sawtooth step is every P cycles; the full ramp is 2^N·P cycles.
- PLAY lasts exactly DUR_TICKS cycles absent retrigger. GAP lasts exactly GAP_TICKS cycles.
- Retrigger at edge j: the j edge reloads counters. At j+1 the phase=0 output is visible, identical to first entry.
- Input change of wave_mode_i/vol_i affects dacCount on the next edge.

## Structure
- Package sound_gen_pkg:
  - sg_state_t enum {SG_IDLE, SG_PLAY, SG_GAP}
  - wave_mode_t enum {WAVE_SQUARE, WAVE_SAW}
  - default period constants for the existing events (goodColl, badColl, button, direction[3:0])
- Sub-module sg_tone_osc, holding the phase counter and sq/saw generation:
  - inputs: clk, rst, load, en, period
  - outputs: sq, saw
- Top holds edge detect, priority encoder, FSM, duration/gap counters, output mux/shift.

## Test plan
Bench parameters: N=8, NUM_EVT=4, DIV_W=8, DUR_TICKS=20, GAP_TICKS=4.
- Basic square: evt_i[2] pulse, period[2]=3, vol=0.
  - busy_o rises 2 edges later; active_evt_o=2.
  - dacCount = 255,255,255,0,0,0,… for 20 cycles.
  - Then 0 with busy_o=1 for 4 cycles, then busy_o=0.
- Priority and simultaneity:
  - evt_i=4'b1010 in one cycle → active_evt_o=1; event 3 is never played.
  - While playing 1, edge on 3 → ignored.
  - Edge on 0 → retrigger: active_evt_o=0, and the duration restarts, giving 20 more cycles.
- Sawtooth and volume: wave_mode=1, period=1, vol=2.
  - dacCount = 0,0,0,0,1,1,1,1,2,… (saw>>2); saw wraps 255→0 at 256 cycles.
  - Use DUR_TICKS=300 variant for this check.
- Gap lockout: edge on event 0 during GAP → ignored, busy_o falls on schedule. The same edge after IDLE → plays.
- Reset and boundaries:
  - rst mid-PLAY → dacCount=0, busy_o=0 next cycle.
  - evt_i held high through reset release → one tone plays.
  - period=0 behaves as period=1.
  - A level held high does not retrigger.
